// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, selector codes, state encoding and control word for the multicycle MIPS32 controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ORIEX  = 4'd11,
    S_IWB    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;
endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: combinational state + mem_ready + reset to datapath control word
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);
  // Moore decode per state; fetch enables follow mem_ready; reset masks every write/request
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop = ALUOP_ADD;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.regdst = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_JR: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsource = PCSRC_REGA;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop = ALUOP_OR;
        ctrl.zeroext = 1'b1;
      end
      S_IWB: ctrl.regwrite = 1'b1;
      default: ctrl = '0;
    endcase
    if (reset) begin
      ctrl.memread = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.irwrite = 1'b0;
      ctrl.pcwrite = 1'b0;
      ctrl.pcwritecond = 1'b0;
      ctrl.regwrite = 1'b0;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM, retire pulse and retired-instruction counter for the multicycle MIPS32 core
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 jrsig,
  input  logic                 mem_ready,
  output logic [1:0]           aluop,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zeroext,
  output logic                 iord,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 pcwrite,
  output logic                 pcwritecond,
  output logic [1:0]           pcsource,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 instr_retired,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] retire_count
);
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic retire, illegal;
  ctrl_t ctrl;

  mc_output_decode u_dec (
    .state(state_q),
    .mem_ready(mem_ready),
    .reset(reset),
    .ctrl(ctrl)
  );

  // Next state plus the retire / illegal pulses, both suppressed under reset
  always_comb begin
    state_d = state_q;
    retire = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire = mem_ready;
      end
      S_EXEC: state_d = jrsig ? S_JR : S_RWB;
      S_ADDIEX, S_ORIEX: state_d = S_IWB;
      S_MEMWB, S_RWB, S_JR, S_BRANCH, S_JUMP, S_IWB: begin
        state_d = S_FETCH;
        retire = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      retire = 1'b0;
      illegal = 1'b0;
    end
    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire};
  end

  // State and counter registers; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  assign aluop = ctrl.aluop;
  assign alusrca = ctrl.alusrca;
  assign alusrcb = ctrl.alusrcb;
  assign zeroext = ctrl.zeroext;
  assign iord = ctrl.iord;
  assign memread = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign irwrite = ctrl.irwrite;
  assign pcwrite = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign pcsource = ctrl.pcsource;
  assign regdst = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign instr_retired = retire;
  assign illegal_op = illegal;
  assign retire_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction cycle-script model checking every control output each cycle
module tb_multicycle_control;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset, jrsig, mem_ready;
  logic [5:0] opcode;
  logic [1:0] aluop, alusrcb, pcsource;
  logic alusrca, zeroext, iord, memread, memwrite, irwrite, pcwrite, pcwritecond;
  logic regdst, memtoreg, regwrite, instr_retired, illegal_op;
  logic [CW-1:0] retire_count;
  int n_checks = 0;
  int n_fail = 0;
  int cnt_m = 0;
  logic [5:0] cur_op;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX, P_RWB, P_BR, P_J, P_AEX, P_OEX, P_IWB, P_JR} phase_e;
  typedef struct {phase_e p; logic mr;} cyc_t;
  cyc_t q[$];

  multicycle_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .jrsig(jrsig), .mem_ready(mem_ready),
    .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcwritecond(pcwritecond), .pcsource(pcsource), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .instr_retired(instr_retired), .illegal_op(illegal_op),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  wire [16:0] act = {aluop, alusrca, alusrcb, zeroext, iord, memread, memwrite, irwrite,
                     pcwrite, pcwritecond, pcsource, regdst, memtoreg, regwrite};
  wire [7:0] enables = {memread, memwrite, irwrite, pcwrite, pcwritecond, regwrite, instr_retired, illegal_op};

  function automatic logic [16:0] exp_ctrl(phase_e p, logic mr);
    logic [1:0] ao, sb, ps;
    logic sa, ze, io, mrd, mwr, irw, pw, pwc, rd, mtr, rw;
    {ao, sb, ps, sa, ze, io, mrd, mwr, irw, pw, pwc, rd, mtr, rw} = '0;
    case (p)
      P_F:   begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      P_D:   sb = 2'b11;
      P_MA:  begin sa = 1; sb = 2'b10; end
      P_MR:  begin mrd = 1; io = 1; end
      P_MWB: begin mtr = 1; rw = 1; end
      P_MW:  begin mwr = 1; io = 1; end
      P_EX:  begin sa = 1; ao = 2'b10; end
      P_RWB: begin rd = 1; rw = 1; end
      P_JR:  begin pw = 1; ps = 2'b11; end
      P_BR:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      P_J:   begin pw = 1; ps = 2'b10; end
      P_AEX: begin sa = 1; sb = 2'b10; end
      P_OEX: begin sa = 1; sb = 2'b10; ao = 2'b11; ze = 1; end
      P_IWB: rw = 1;
      default: ;
    endcase
    return {ao, sa, sb, ze, io, mrd, mwr, irw, pw, pwc, ps, rd, mtr, rw};
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001101};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // script of cycles an instruction takes, with the mem_ready value to present in each
  task automatic build(input logic [5:0] op, input logic jr, input int fw, input int mw);
    q.delete();
    repeat (fw) q.push_back('{P_F, 1'b0});
    q.push_back('{P_F, 1'b1});
    q.push_back('{P_D, rnd()});
    if (op == 6'b000000) begin
      q.push_back('{P_EX, rnd()});
      q.push_back('{jr ? P_JR : P_RWB, rnd()});
    end else if (op == 6'b100011 || op == 6'b101011) begin
      q.push_back('{P_MA, rnd()});
      repeat (mw) q.push_back('{op == 6'b100011 ? P_MR : P_MW, 1'b0});
      q.push_back('{op == 6'b100011 ? P_MR : P_MW, 1'b1});
      if (op == 6'b100011) q.push_back('{P_MWB, rnd()});
    end else if (op == 6'b000100) q.push_back('{P_BR, rnd()});
    else if (op == 6'b000010) q.push_back('{P_J, rnd()});
    else if (op == 6'b001000 || op == 6'b001101) begin
      q.push_back('{op == 6'b001000 ? P_AEX : P_OEX, rnd()});
      q.push_back('{P_IWB, rnd()});
    end
    cur_op = op;
    opcode = op;
    jrsig = jr;
  endtask

  task automatic run_q(input int n, input string nm);
    logic [16:0] e;
    logic [1:0] ef;
    for (int i = 0; i < n; i++) begin
      mem_ready = q[i].mr;
      #2;
      e = exp_ctrl(q[i].p, q[i].mr);
      ef = {(i == q.size() - 1) && legal(cur_op), !legal(cur_op) && q[i].p == P_D};
      n_checks += 3;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s ctrl cyc%0d: got %b expected %b", nm, i, act, e);
      end
      if ({instr_retired, illegal_op} !== ef) begin
        n_fail++;
        $display("FAIL %s retired/illegal cyc%0d: got %b expected %b", nm, i, {instr_retired, illegal_op}, ef);
      end
      if (retire_count !== CW'(cnt_m)) begin
        n_fail++;
        $display("FAIL %s retire_count cyc%0d: got %0d expected %0d", nm, i, retire_count, cnt_m);
      end
      @(posedge clk);
      if (ef[1]) cnt_m = (cnt_m + 1) % (1 << CW);
      #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic jr, input int fw, input int mw, input string nm);
    build(op, jr, fw, mw);
    run_q(q.size(), nm);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    jrsig = 1'b0;
    opcode = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++;
      if (enables !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_enables: got %b expected 00000000", enables);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (retire_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", retire_count);
    end
    reset = 1'b0;
    cnt_m = 0;
  endtask

  task automatic test_rtype_add(); run_instr(6'b000000, 1'b0, 0, 0, "rtype_add"); endtask
  task automatic test_lw_wait(); run_instr(6'b100011, 1'b0, 0, 3, "lw_wait"); endtask
  task automatic test_beq(); run_instr(6'b000100, 1'b1, 0, 0, "beq"); endtask
  task automatic test_jr_ori();
    run_instr(6'b000000, 1'b1, 1, 0, "jr");
    run_instr(6'b001101, 1'b0, 0, 0, "ori");
    run_instr(6'b001000, 1'b1, 2, 0, "addi");
    run_instr(6'b101011, 1'b0, 0, 0, "sw");
  endtask
  task automatic test_illegal();
    run_instr(6'b111111, 1'b0, 0, 0, "illegal_3f");
    run_instr(6'b000001, 1'b0, 1, 0, "illegal_01");
  endtask

  task automatic test_sw_reset_abort();
    build(6'b101011, 1'b0, 0, 5);
    run_q(4, "sw_abort_pre");
    reset = 1'b1;
    mem_ready = 1'b0;
    #2;
    n_checks++;
    if ({memwrite, instr_retired, enables} !== 10'b0) begin
      n_fail++;
      $display("FAIL sw_abort_in_reset: memwrite=%b retired=%b enables=%b expected all 0", memwrite, instr_retired, enables);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt_m = 0;
    run_instr(6'b000010, 1'b0, 0, 0, "after_abort_j");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 18; i++) run_instr(6'b000010, 1'b0, 0, 0, "wrap_j");
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001101, 6'b111111};
    logic [5:0] op;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 6'b111111) op = 6'($urandom);
      run_instr(op, rnd(), $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_lw_wait();
    test_beq();
    test_jr_ori();
    test_illegal();
    test_sw_reset_abort();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main sequencing FSM for the multicycle MIPS32 core. Steps each instruction through fetch, decode, execute, memory and writeback. Drives the ALU's 2-bit aluop, the operand/PC/register-file/memory control lines, and a retired-instruction counter. Memory accesses stall on a mem_ready handshake. jrsig comes back from the ALU control decoder during R-type execute and selects the jr path.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  instruction[31:26] from the instruction register
jrsig  input  1  jr indication from the ALU control decoder; valid only while aluop=10
mem_ready  input  1  memory completes the current read/write this cycle
aluop  output  2  00 add, 01 sub, 10 use funct, 11 or
alusrca  output  1  0 = PC, 1 = register A
alusrcb  output  2  00 reg B, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2
zeroext  output  1  1 = zero-extend immediate (ori)
iord  output  1  0 = PC address, 1 = ALUOut address
memread  output  1  memory read request
memwrite  output  1  memory write request
irwrite  output  1  load instruction register
pcwrite  output  1  unconditional PC load
pcwritecond  output  1  PC load if ALU zero
pcsource  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 register A
regdst  output  1  1 = rd, 0 = rt
memtoreg  output  1  1 = MDR, 0 = ALUOut
regwrite  output  1  register file write
instr_retired  output  1  one-cycle pulse on instruction completion
illegal_op  output  1  one-cycle pulse for an unsupported opcode
retire_count  output  CNT_WIDTH  retired-instruction count, wraps

Behaviour:
- State register is 4 bits. Encoding: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 RWB7 BRANCH8 JUMP9 ADDIEX10 ORIEX11 IWB12 JR13. Codes 14 and 15 go to FETCH on the next edge.
- All outputs are decoded from the state (Moore), except the enables that depend on mem_ready. Any output not listed for a state is 0.
- Reset: state goes to FETCH and retire_count goes to 0 on the edge. While reset is high, memread, memwrite, irwrite, pcwrite, pcwritecond, regwrite, instr_retired and illegal_op are forced to 0. A reset during any state, including a memory wait, aborts that instruction with no retire.
- FETCH: memread=1, alusrcb=01, aluop=00, and irwrite=pcwrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alusrcb=11, aluop=00 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - 001101 -> ORIEX
  - any other opcode -> FETCH with illegal_op=1
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw. The opcode is held stable by the IR.
- MEMRD: memread=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: memtoreg=1, regwrite=1, regdst=0. Goes to FETCH and retires.
- MEMWR: memwrite=1, iord=1. Waits for mem_ready, then goes to FETCH and retires in the cycle mem_ready is seen.
- EXEC: alusrca=1, alusrcb=00, aluop=10. jrsig=1 -> JR, otherwise -> RWB.
- RWB: regdst=1, regwrite=1. Goes to FETCH and retires.
- JR: pcwrite=1, pcsource=11. Goes to FETCH and retires.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Goes to FETCH and retires.
- JUMP: pcwrite=1, pcsource=10. Goes to FETCH and retires.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to IWB.
- ORIEX: alusrca=1, alusrcb=10, aluop=11, zeroext=1. Goes to IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Goes to FETCH and retires.
- instr_retired is combinational, high in the final cycle of each instruction as defined above.
- retire_count increments on the same edge as instr_retired and wraps from all-ones to 0.
- Illegal opcodes do not count.
- Ideal-memory latency: R-type, jr, addi and ori take 4 cycles; lw takes 5; sw takes 4; beq and j take 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI)
  - aluop constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_OR)
  - state encodings
  - pcsource and alusrcb selector constants
- One sub-module, mc_output_decode, is natural: a purely combinational state + mem_ready + reset -> control-word decoder. multicycle_control keeps the state register, next-state logic and retire counter.

Test Plan:
- reset high 2 cycles, then low with opcode=000000, funct add, mem_ready=1 -> states 0,1,6,7. aluop=10 in the EXEC cycle; regwrite=1 and regdst=1 in cycle 4; retire_count 0->1.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4 (8 cycles). memread=1 and iord=1 throughout MEMRD; memtoreg=1 and regwrite=1 in the last cycle.
- beq (000100) -> 3 cycles. In cycle 3: aluop=01, pcwritecond=1, pcsource=01; instr_retired=1.
- R-type with jrsig=1 during EXEC -> next state JR with pcwrite=1 and pcsource=11, regwrite never 1; ori (001101) -> ORIEX with aluop=11 and zeroext=1, then IWB with regwrite=1.
- opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH; retire_count unchanged.
- sw with mem_ready=0, reset asserted in the second MEMWR cycle -> memwrite=0 that same cycle, state=FETCH next, retire_count=0, no instr_retired.
